// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller:
// state encoding, lamp patterns and sequence helpers.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G      = 3'd0,
      NS_Y      = 3'd1,
      RED_A     = 3'd2,
      EW_G      = 3'd3,
      EW_Y      = 3'd4,
      RED_B     = 3'd5,
      FLASH_ON  = 3'd6,
      FLASH_OFF = 3'd7
   } state_t;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // Successor in the day-time rotation
   function automatic state_t next_normal(input state_t s);
      state_t n;
      case (s)
         NS_G:    n = NS_Y;
         NS_Y:    n = RED_A;
         RED_A:   n = EW_G;
         EW_G:    n = EW_Y;
         EW_Y:    n = RED_B;
         default: n = NS_G;
      endcase
      return n;
   endfunction

   function automatic logic is_flash(input state_t s);
      return (s == FLASH_ON) || (s == FLASH_OFF);
   endfunction

endpackage

// File: rtl/edge_tick.sv
// Synchronizes a slow asynchronous level and emits
// a one-cycle pulse per rising edge.
module edge_tick (
   input  logic click,
   input  logic rst_n,
   input  logic level,
   output logic tick
);

   logic s1;
   logic s2;
   logic s3;

   // Two-flop synchronizer, delay flop and registered rise pulse
   always_ff @(posedge click) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         tick <= 1'b0;
      end else begin
         s1   <= level;
         s2   <= s1;
         s3   <= s2;
         tick <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-direction traffic light sequencer driven by
// ticks derived from the divided slow clock.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 3,
   parameter int RED_T    = 1
) (
   input  logic       click,
   input  logic       rst_n,
   input  logic       slow_clk,
   input  logic       hold,
   input  logic       night,
   output logic       tick,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [7:0] remain
);

   localparam logic [7:0] G_LD = 8'(GREEN_T - 1);
   localparam logic [7:0] Y_LD = 8'(YELLOW_T - 1);
   localparam logic [7:0] R_LD = 8'(RED_T - 1);

   state_t     state;
   state_t     state_nx;
   logic [7:0] remain_nx;
   logic [2:0] ns_nx;
   logic [2:0] ew_nx;

   // Countdown value loaded on entry to a state
   function automatic logic [7:0] dur_ld(input state_t s);
      logic [7:0] d;
      case (s)
         NS_G, EW_G:   d = G_LD;
         NS_Y, EW_Y:   d = Y_LD;
         RED_A, RED_B: d = R_LD;
         default:      d = 8'd0;
      endcase
      return d;
   endfunction

   edge_tick u_edge (
      .click (click),
      .rst_n (rst_n),
      .level (slow_clk),
      .tick  (tick)
   );

   // Next state and countdown: hold beats night beats countdown
   always_comb begin
      state_nx  = state;
      remain_nx = remain;
      if (tick && !hold) begin
         if (night) begin
            remain_nx = 8'd0;
            state_nx  = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
         end else if (is_flash(state)) begin
            state_nx  = RED_B;
            remain_nx = R_LD;
         end else if (remain != 8'd0) begin
            remain_nx = remain - 8'd1;
         end else begin
            state_nx  = next_normal(state);
            remain_nx = dur_ld(state_nx);
         end
      end
   end

   // Lamp decode of the upcoming state so lamps track state
   always_comb begin
      ns_nx = LAMP_R;
      ew_nx = LAMP_R;
      case (state_nx)
         NS_G:      ns_nx = LAMP_G;
         NS_Y:      ns_nx = LAMP_Y;
         EW_G:      ew_nx = LAMP_G;
         EW_Y:      ew_nx = LAMP_Y;
         FLASH_ON: begin
            ns_nx = LAMP_Y;
            ew_nx = LAMP_Y;
         end
         FLASH_OFF: begin
            ns_nx = LAMP_OFF;
            ew_nx = LAMP_OFF;
         end
         default: begin
            ns_nx = LAMP_R;
            ew_nx = LAMP_R;
         end
      endcase
   end

   // State, countdown and lamp registers
   always_ff @(posedge click) begin
      if (!rst_n) begin
         state    <= NS_G;
         remain   <= G_LD;
         ns_light <= LAMP_G;
         ew_light <= LAMP_R;
      end else begin
         state    <= state_nx;
         remain   <= remain_nx;
         ns_light <= ns_nx;
         ew_light <= ew_nx;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with
// hand-computed lamp and countdown expectations.
module tb_traffic_light_ctrl;

   logic       click = 1'b0;
   logic       rst_n = 1'b0;
   logic       slow_clk = 1'b0;
   logic       hold = 1'b0;
   logic       night = 1'b0;
   logic       tick;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic [7:0] remain;

   int  errors = 0;
   int  checks = 0;
   logic run = 1'b0;
   logic mon = 1'b0;
   int  ph = 0;
   int  nt;

   // Full rotation after each tick from NS_G remain 3
   logic [2:0] e_ns [14] = '{3'b001, 3'b001, 3'b001,
      3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100,
      3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
   logic [2:0] e_ew [14] = '{3'b100, 3'b100, 3'b100,
      3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001,
      3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
   logic [7:0] e_rm [14] = '{8'd2, 8'd1, 8'd0,
      8'd1, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1,
      8'd0, 8'd1, 8'd0, 8'd0, 8'd3};

   traffic_light_ctrl #(
      .GREEN_T  (4),
      .YELLOW_T (2),
      .RED_T    (1)
   ) dut (
      .click    (click),
      .rst_n    (rst_n),
      .slow_clk (slow_clk),
      .hold     (hold),
      .night    (night),
      .tick     (tick),
      .ns_light (ns_light),
      .ew_light (ew_light),
      .remain   (remain)
   );

   always #5 click = ~click;

   // Square wave with an 8-click period
   always @(negedge click) begin
      if (run) begin
         ph = ph + 1;
         if (ph == 4) begin
            ph = 0;
            slow_clk = ~slow_clk;
         end
      end
   end

   task automatic check(input string tag,
                        input logic [7:0] got,
                        input logic [7:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Lamp safety and one-hot every cycle in the random phase
   always @(negedge click) begin
      if (mon) begin
         check("safe",
               8'((ns_light == 3'b100) || (ew_light == 3'b100) ||
                  ((ns_light == ew_light) &&
                   (ns_light == 3'b010 || ns_light == 3'b000))),
               8'd1);
         check("onehot",
               8'($onehot0(ns_light) && $onehot0(ew_light)),
               8'd1);
      end
   end

   // Wait for a tick, then sample after the FSM consumed it
   task automatic next_tick();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge click);
         if (tick) begin
            seen = 1'b1;
            break;
         end
      end
      check("tick_seen", 8'(seen), 8'd1);
      @(negedge click);
   endtask

   task automatic expect_st(input string tag,
                            input logic [2:0] ns,
                            input logic [2:0] ew,
                            input logic [7:0] rm);
      check({tag, "_ns"}, 8'(ns_light), 8'(ns));
      check({tag, "_ew"}, 8'(ew_light), 8'(ew));
      check({tag, "_rm"}, remain, rm);
   endtask

   task automatic do_reset();
      @(negedge click);
      rst_n = 1'b0;
      @(negedge click);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge click);
      rst_n = 1'b1;
      check("rst_tick", 8'(tick), 8'd0);
      expect_st("rst", 3'b001, 3'b100, 8'd3);

      // Single rise held high: one tick on 3rd edge
      repeat (4) @(negedge click);
      slow_clk = 1'b1;
      @(negedge click);
      check("edge1", 8'(tick), 8'd0);
      @(negedge click);
      check("edge2", 8'(tick), 8'd0);
      @(negedge click);
      check("edge3", 8'(tick), 8'd1);
      @(negedge click);
      check("edge4", 8'(tick), 8'd0);
      check("edge_rm", remain, 8'd2);
      nt = 0;
      repeat (46) begin
         @(negedge click);
         if (tick) nt = nt + 1;
      end
      check("held_ticks", 8'(nt), 8'd0);
      slow_clk = 1'b0;
      repeat (20) begin
         @(negedge click);
         if (tick) nt = nt + 1;
      end
      check("fall_ticks", 8'(nt), 8'd0);

      // Full rotation
      do_reset();
      expect_st("rst2", 3'b001, 3'b100, 8'd3);
      run = 1'b1;
      for (int i = 0; i < 14; i++) begin
         next_tick();
         expect_st($sformatf("seq%0d", i),
                   e_ns[i], e_ew[i], e_rm[i]);
      end

      // Hold during EW_G with remain 2
      repeat (8) next_tick();
      expect_st("pre_hold", 3'b100, 3'b001, 8'd2);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_tick();
         expect_st($sformatf("hold%0d", i),
                   3'b100, 3'b001, 8'd2);
      end
      hold = 1'b0;
      next_tick();
      expect_st("rel0", 3'b100, 3'b001, 8'd1);
      next_tick();
      expect_st("rel1", 3'b100, 3'b001, 8'd0);
      next_tick();
      expect_st("rel2", 3'b100, 3'b010, 8'd1);

      // Night mode from NS_G remain 2
      repeat (4) next_tick();
      expect_st("pre_night", 3'b001, 3'b100, 8'd2);
      night = 1'b1;
      next_tick();
      expect_st("fl_on0", 3'b010, 3'b010, 8'd0);
      next_tick();
      expect_st("fl_off", 3'b000, 3'b000, 8'd0);
      next_tick();
      expect_st("fl_on1", 3'b010, 3'b010, 8'd0);
      night = 1'b0;
      next_tick();
      expect_st("day_redb", 3'b100, 3'b100, 8'd0);
      next_tick();
      expect_st("day_nsg", 3'b001, 3'b100, 8'd3);

      // Reset mid EW_Y
      repeat (11) next_tick();
      expect_st("pre_rst", 3'b100, 3'b010, 8'd1);
      do_reset();
      check("mid_rst_tick", 8'(tick), 8'd0);
      expect_st("mid_rst", 3'b001, 3'b100, 8'd3);

      // Random hold/night with invariant monitor
      mon = 1'b1;
      repeat (1000) begin
         next_tick();
         hold  = ($urandom_range(0, 3) == 0);
         night = ($urandom_range(0, 4) == 0);
      end
      mon = 1'b0;
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
